icache_fetch_responder: RTL and testbench

//   Instruction-side responder that serves the core's fetch requests: a

---
 rtl/icache_fetch_responder.sv | 192 +++++++++++++++++++
 tb/tb_icache_fetch_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache serving core fetch requests.
// Hits return the word one cycle after the strobe; misses refill the
// whole line from backing memory in word order, then return the word.
module icache_fetch_responder #(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en_i,
  input  logic              flush_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_valid_o,
  output logic [31:0]       fetch_data_o,
  output logic              fetch_busy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = {OFFSET_W{1'b1}};
  localparam logic [OFFSET_W-1:0] ONE_WORD  = OFFSET_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Valid bits are reset; tag and data storage is not.
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_arr_q [LINES];
  logic [31:0]         data_arr_q [LINES*WORDS];

  // Line being refilled and the word the core asked for.
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]  req_index_q, req_index_d;
  logic [OFFSET_W-1:0] req_offset_q, req_offset_d;
  logic [OFFSET_W-1:0] word_cnt_q, word_cnt_d;

  logic                fetch_valid_q, fetch_valid_d;
  logic [31:0]         fetch_data_q, fetch_data_d;
  logic                fetch_busy_q, fetch_busy_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic                data_we_s;
  logic                tag_we_s;
  logic [TAG_W-1:0]    in_tag_s;
  logic [INDEX_W-1:0]  in_index_s;
  logic [OFFSET_W-1:0] in_offset_s;
  logic                hit_s;
  logic                last_word_s;
  logic [OFFSET_W-1:0] next_word_s;

  assign in_tag_s    = fetch_addr_i[ADDR_W-1 -: TAG_W];
  assign in_index_s  = fetch_addr_i[OFFSET_W +: INDEX_W];
  assign in_offset_s = fetch_addr_i[OFFSET_W-1:0];
  assign hit_s       = valid_q[in_index_s] && (tag_arr_q[in_index_s] == in_tag_s);
  assign last_word_s = (word_cnt_q == LAST_WORD);
  // Offset arithmetic wraps inside the line, never carrying into index/tag.
  assign next_word_s = word_cnt_q + ONE_WORD;

  // Next-state, array write enables and output register inputs.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    req_tag_d     = req_tag_q;
    req_index_d   = req_index_q;
    req_offset_d  = req_offset_q;
    word_cnt_d    = word_cnt_q;
    fetch_valid_d = fetch_valid_q;
    fetch_data_d  = fetch_data_q;
    fetch_busy_d  = fetch_busy_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    data_we_s     = 1'b0;
    tag_we_s      = 1'b0;

    if (!clk_en_i) begin
      // Clock-enable low: everything holds, flush included.
      data_we_s = 1'b0;
    end else if (flush_i) begin
      // Flush wins over any fetch strobe or refill beat in the same cycle.
      valid_d       = '0;
      state_d       = ST_IDLE;
      mem_req_d     = 1'b0;
      fetch_busy_d  = 1'b0;
      fetch_valid_d = 1'b0;
    end else begin
      fetch_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fetch_req_i && hit_s) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = data_arr_q[{in_index_s, in_offset_s}];
          end else if (fetch_req_i) begin
            req_tag_d    = in_tag_s;
            req_index_d  = in_index_s;
            req_offset_d = in_offset_s;
            word_cnt_d   = '0;
            state_d      = ST_REFILL;
            mem_req_d    = 1'b1;
            fetch_busy_d = 1'b1;
            mem_addr_d   = {in_tag_s, in_index_s, {OFFSET_W{1'b0}}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REFILL: begin
          if (mem_rvalid_i && mem_req_q) begin
            data_we_s = 1'b1;
            if (last_word_s) begin
              tag_we_s              = 1'b1;
              valid_d[req_index_q]  = 1'b1;
              state_d               = ST_IDLE;
              mem_req_d             = 1'b0;
              fetch_busy_d          = 1'b0;
              fetch_valid_d         = 1'b1;
              // The last word is still in flight to the array, so bypass it.
              fetch_data_d = (req_offset_q == LAST_WORD) ? mem_rdata_i
                                                         : data_arr_q[{req_index_q, req_offset_q}];
            end else begin
              word_cnt_d = next_word_s;
              mem_addr_d = {req_tag_q, req_index_q, next_word_s};
            end
          end else begin
            state_d = ST_REFILL;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          mem_req_d    = 1'b0;
          fetch_busy_d = 1'b0;
        end
      endcase
    end
  end

  // Control state and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      req_tag_q     <= '0;
      req_index_q   <= '0;
      req_offset_q  <= '0;
      word_cnt_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= 32'h0000_0000;
      fetch_busy_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      req_tag_q     <= req_tag_d;
      req_index_q   <= req_index_d;
      req_offset_q  <= req_offset_d;
      word_cnt_q    <= word_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_busy_q  <= fetch_busy_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  // Tag and data storage writes; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      data_arr_q[{req_index_q, word_cnt_q}] <= mem_rdata_i;
    end
    if (tag_we_s) begin
      tag_arr_q[req_index_q] <= req_tag_q;
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_data_o  = fetch_data_q;
  assign fetch_busy_o  = fetch_busy_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: a driver issues fetches and
// predicts hit/miss from a line-residency model, a memory responder serves
// refills from a fixed memory image, and a monitor checks every response.
module tb_icache_fetch_responder;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        flush;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  icache_fetch_responder dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en_i     (clk_en),
    .flush_i      (flush),
    .fetch_req_i  (fetch_req),
    .fetch_addr_i (fetch_addr),
    .fetch_valid_o(fetch_valid),
    .fetch_data_o (fetch_data),
    .fetch_busy_o (fetch_busy),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_word = 0;
  int          fill_done_cyc = -1;
  int          miss_seq = 0;
  logic [15:0] line_base = 16'h0000;
  bit          resp_en = 1'b1;
  bit          rand_lat = 1'b0;
  bit          stray = 1'b0;
  bit          res_valid[8];
  logic [10:0] res_tag[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory image: fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    if (a >= 16'h0010 && a <= 16'h0013) w = 32'h0000_00A0 + {30'd0, a[1:0]};
    else w = {a ^ 16'hC3A5, a};
    return w;
  endfunction

  function automatic int next_lat();
    return rand_lat ? int'($urandom_range(0, 3)) : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {31'd0, act}, {31'd0, req});
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  // Memory responder: answers after a latency, one word per mem_rvalid pulse.
  initial begin : responder
    int          lat;
    bit          prev_req;
    bit          consumed;
    int          seen_seq;
    logic [15:0] held;
    lat = 2; prev_req = 1'b0; seen_seq = 0; held = 16'h0000;
    mem_rvalid = 1'b0; mem_rdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      #1;
      if (!resp_en) begin
        mem_rvalid = stray;
        mem_rdata  = 32'hDEAD_BEEF;
        lat = next_lat();
      end else begin
        if (seen_seq != miss_seq) begin
          seen_seq = miss_seq;
          exp_word = 0;
        end
        consumed = mem_rvalid && prev_req && clk_en && !flush && !rst;
        if (consumed) begin
          if (exp_word == 3) fill_done_cyc = cyc;
          exp_word++;
          mem_rvalid = 1'b0;
          lat = next_lat();
        end
        if (!mem_req) begin
          mem_rvalid = 1'b0;
          lat = next_lat();
        end else if (mem_rvalid) begin
          chk("mem_addr_stable", {16'd0, mem_addr}, {16'd0, held});
        end else if (lat == 0) begin
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, line_base + 16'(exp_word)});
          held       = mem_addr;
          mem_rdata  = mem_word(mem_addr);
          mem_rvalid = 1'b1;
        end else begin
          lat--;
        end
      end
      prev_req = mem_req;
    end
  end

  // Monitor: every fetch_valid pulse must match the oldest expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: actual data=%h required=no response", fetch_data);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_data", fetch_data, e.data);
          chk("fetch_latency", cyc, e.hit ? e.due : fill_done_cyc);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 8; i++) res_valid[i] = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a, input bit strobe_busy);
    exp_t        e;
    int          n;
    logic [2:0]  idx;
    logic [10:0] tg;
    n = 0;
    while (fetch_busy && n < 300) begin
      fetch_req  = strobe_busy && ($urandom_range(0, 3) == 0);
      fetch_addr = 16'($urandom);
      step();
      n++;
    end
    chk1("idle_wait", fetch_busy, 1'b0);
    idx    = a[4:2];
    tg     = a[15:5];
    e.data = mem_word(a);
    e.hit  = res_valid[idx] && (res_tag[idx] == tg);
    e.due  = cyc + 1;
    if (!e.hit) begin
      line_base = {a[15:2], 2'b00};
      miss_seq++;
      res_valid[idx] = 1'b1;
      res_tag[idx]   = tg;
    end
    exp_q.push_back(e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    chk1("mem_req_after_req", mem_req, !e.hit);
    chk1("busy_after_req", fetch_busy, !e.hit);
    if (!e.hit) chk("mem_addr_first", {16'd0, mem_addr}, {16'd0, line_base});
  endtask

  task automatic do_flush(input bit with_req);
    exp_t e;
    if (fetch_busy) e = exp_q.pop_back();
    clear_model();
    flush      = 1'b1;
    fetch_req  = with_req;
    fetch_addr = 16'($urandom_range(0, 127));
    step();
    flush     = 1'b0;
    fetch_req = 1'b0;
    chk1("flush_mem_req", mem_req, 1'b0);
    chk1("flush_busy", fetch_busy, 1'b0);
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (exp_word < n && k < 300) begin
      step();
      k++;
    end
    chk("refill_progress", exp_word, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fetch_busy) && k < 300) begin
      step();
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic stray_pulse();
    resp_en = 1'b0;
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    repeat (3) step();
    resp_en = 1'b1;
  endtask

  initial begin : driver
    exp_t        e;
    int          r;
    logic [15:0] a;
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; fetch_req = 1'b0; fetch_addr = 16'h0000;
    clear_model();
    repeat (2) step();
    chk1("rst_fetch_valid", fetch_valid, 1'b0);
    chk1("rst_fetch_busy", fetch_busy, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_fetch_data", fetch_data, 32'h0000_0000);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0000_0000);
    rst = 1'b0;
    step();

    // Cold miss on 0x0012, then hit stream over the same line.
    issue(16'h0012, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) issue(16'h0010 + 16'(i), 1'b0);
    drain();

    // Conflict on index 4: evict, then miss again on the original line.
    issue(16'h0032, 1'b0);
    drain();
    issue(16'h0012, 1'b0);
    drain();

    // Flush after the second refill beat aborts without a response.
    issue(16'h0032, 1'b0);
    wait_words(2);
    do_flush(1'b0);
    repeat (6) step();
    issue(16'h0012, 1'b0);
    drain();

    // Clock enable low mid-refill freezes address and outputs.
    issue(16'h0052, 1'b0);
    wait_words(1);
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("gated_mem_addr", {16'd0, mem_addr}, {16'd0, line_base + 16'd1});
      chk1("gated_mem_req", mem_req, 1'b1);
      chk1("gated_busy", fetch_busy, 1'b1);
      chk1("gated_valid", fetch_valid, 1'b0);
    end
    clk_en = 1'b1;
    drain();

    // Asynchronous reset mid-refill, then a stray memory beat.
    issue(16'h0072, 1'b0);
    wait_words(1);
    resp_en = 1'b0;
    if (fetch_busy) e = exp_q.pop_back();
    clear_model();
    rst = 1'b1;
    #1;
    chk1("async_rst_valid", fetch_valid, 1'b0);
    chk1("async_rst_busy", fetch_busy, 1'b0);
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk("async_rst_mem_addr", {16'd0, mem_addr}, 32'h0000_0000);
    chk("async_rst_data", fetch_data, 32'h0000_0000);
    step();
    rst = 1'b0;
    step();
    stray_pulse();

    // A stray beat with a valid line resident must not corrupt it.
    issue(16'h0000, 1'b0);
    drain();
    stray_pulse();
    for (int i = 0; i < 4; i++) issue(16'(i), 1'b0);
    drain();

    // Randomized traffic with random memory latency, flushes and busy strobes.
    rand_lat = 1'b1;
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      a = 16'($urandom_range(0, 127));
      if (r < 80) issue(a, 1'b1);
      else if (r < 86) do_flush(1'b0);
      else if (r < 90) do_flush(1'b1);
      else step();
    end
    drain();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
